// File: rtl/xc_malu_seq_if.sv
// Request/response bus and MALU-side signals of the xc_malu_seq sequencer.
// The sequencer uses the slave modport. Whatever sits around it uses the
// master modport: it issues requests, takes responses and returns the MALU
// results.
//
// Handshakes: a transfer happens on a rising clock edge where valid && ready.
// The side raising valid keeps valid and its payload stable until that edge.
// The req and rsp channels follow this rule. On the MALU side,
// malu_valid/operands stay stable until malu_flush (malu_valid && malu_ready,
// or a watchdog abort) is seen.
interface xc_malu_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic        req_lh_sign;
  logic        req_rh_sign;
  logic        req_carryless;
  logic [2:0]  req_pw;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [31:0] req_rs3;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic        rsp_err;

  logic        malu_valid;
  logic        malu_flush;
  logic [6:0]  malu_uop;
  logic        malu_lh_sign;
  logic        malu_rh_sign;
  logic        malu_carryless;
  logic [4:0]  malu_pw;
  logic [31:0] malu_rs1;
  logic [31:0] malu_rs2;
  logic [31:0] malu_rs3;
  logic [63:0] malu_result_mul;
  logic [31:0] malu_result_div_q;
  logic [31:0] malu_result_div_r;
  logic        malu_ready;

  modport slave (
    input  req_valid, req_op, req_lh_sign, req_rh_sign, req_carryless, req_pw,
           req_rs1, req_rs2, req_rs3,
    output req_ready,
    output rsp_valid, rsp_result, rsp_err,
    input  rsp_ready,
    output malu_valid, malu_flush, malu_uop, malu_lh_sign, malu_rh_sign,
           malu_carryless, malu_pw, malu_rs1, malu_rs2, malu_rs3,
    input  malu_result_mul, malu_result_div_q, malu_result_div_r, malu_ready
  );

  modport master (
    output req_valid, req_op, req_lh_sign, req_rh_sign, req_carryless, req_pw,
           req_rs1, req_rs2, req_rs3,
    input  req_ready,
    input  rsp_valid, rsp_result, rsp_err,
    output rsp_ready,
    input  malu_valid, malu_flush, malu_uop, malu_lh_sign, malu_rh_sign,
           malu_carryless, malu_pw, malu_rs1, malu_rs2, malu_rs3,
    output malu_result_mul, malu_result_div_q, malu_result_div_r, malu_ready
  );
endinterface

// File: rtl/xc_malu_seq.sv
// Instruction-level sequencer in front of xc_malu. It takes one request per
// handshake and issues one micro-op (DIVREM/MUL/MADD) or two micro-ops
// (MSUB/MACC). It then returns a 64-bit result with an error flag. A
// per-micro-op watchdog aborts a MALU operation that never completes.
module xc_malu_seq #(
  parameter int unsigned MAX_CYCLES = 64
) (
  input  logic         clock,
  input  logic         resetn,
  xc_malu_seq_if.slave bus,
  output logic [1:0]   dbg_state
);

  // One-hot micro-op encoding {drem,mul,madd,msub_1,msub_2,macc_1,macc_2}.
  // The second phase of MSUB/MACC sits one bit below its first phase.
  localparam logic [6:0] UOP_DREM   = 7'b1000000;
  localparam logic [6:0] UOP_MUL    = 7'b0100000;
  localparam logic [6:0] UOP_MADD   = 7'b0010000;
  localparam logic [6:0] UOP_MSUB_1 = 7'b0001000;
  localparam logic [6:0] UOP_MACC_1 = 7'b0000010;

  // One-hot packed width {pw_32,pw_16,pw_8,pw_4,pw_2}.
  localparam logic [4:0] PW_32 = 5'b10000;
  localparam logic [4:0] PW_16 = 5'b01000;
  localparam logic [4:0] PW_8  = 5'b00100;
  localparam logic [4:0] PW_4  = 5'b00010;
  localparam logic [4:0] PW_2  = 5'b00001;

  localparam logic [7:0] WD_LAST = 8'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE1 = 2'd1,
    ISSUE2 = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      state_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [63:0] rsp_result_q;
  logic        malu_valid_q;
  logic [6:0]  malu_uop_q;
  logic        lh_sign_q;
  logic        rh_sign_q;
  logic        carryless_q;
  logic [4:0]  pw_q;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic [31:0] rs3_q;
  logic [7:0]  wd_q;

  logic [6:0]  dec_uop;
  logic [4:0]  dec_pw;
  logic        dec_illegal;
  logic        malu_done;
  logic        wd_hit;

  // Decode the incoming request into one-hot first uop and packed width.
  always_comb begin
    dec_uop     = '0;
    dec_pw      = '0;
    dec_illegal = 1'b0;
    case (bus.req_op)
      3'd0:    dec_uop = UOP_DREM;
      3'd1:    dec_uop = UOP_MUL;
      3'd2:    dec_uop = UOP_MADD;
      3'd3:    dec_uop = UOP_MSUB_1;
      3'd4:    dec_uop = UOP_MACC_1;
      default: dec_illegal = 1'b1;
    endcase
    case (bus.req_pw)
      3'd0:    dec_pw = PW_32;
      3'd1:    dec_pw = PW_16;
      3'd2:    dec_pw = PW_8;
      3'd3:    dec_pw = PW_4;
      3'd4:    dec_pw = PW_2;
      default: dec_illegal = 1'b1;
    endcase
    // Division always runs at full width.
    if (bus.req_op == 3'd0) begin
      dec_pw = PW_32;
    end
  end

  // A micro-op ends on MALU completion, or on the cycle in which the watchdog
  // reaches its limit. Completion in that same cycle takes priority.
  assign malu_done = malu_valid_q && bus.malu_ready;
  assign wd_hit    = malu_valid_q && !bus.malu_ready && (wd_q == WD_LAST);

  // Request / micro-op / response sequencing with registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_result_q <= '0;
      malu_valid_q <= 1'b0;
      malu_uop_q   <= '0;
      lh_sign_q    <= 1'b0;
      rh_sign_q    <= 1'b0;
      carryless_q  <= 1'b0;
      pw_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rs3_q        <= '0;
      wd_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            wd_q        <= '0;
            if (dec_illegal) begin
              state_q      <= RESP;
              rsp_valid_q  <= 1'b1;
              rsp_err_q    <= 1'b1;
              rsp_result_q <= '0;
            end else begin
              state_q      <= ISSUE1;
              malu_valid_q <= 1'b1;
              malu_uop_q   <= dec_uop;
              lh_sign_q    <= bus.req_lh_sign;
              // DIVREM uses one signedness for both operands.
              rh_sign_q    <= (bus.req_op == 3'd0) ? bus.req_lh_sign : bus.req_rh_sign;
              carryless_q  <= (bus.req_op == 3'd1) && bus.req_carryless;
              pw_q         <= dec_pw;
              rs1_q        <= bus.req_rs1;
              rs2_q        <= bus.req_rs2;
              rs3_q        <= bus.req_rs3;
            end
          end
        end
        ISSUE1, ISSUE2: begin
          if (!malu_valid_q) begin
            // Idle gap cycle between phases; start phase two now.
            malu_valid_q <= 1'b1;
            wd_q         <= '0;
          end else if (malu_done) begin
            malu_valid_q <= 1'b0;
            wd_q         <= '0;
            if ((state_q == ISSUE1) && (malu_uop_q[3] || malu_uop_q[1])) begin
              state_q    <= ISSUE2;
              malu_uop_q <= malu_uop_q >> 1;
              rs3_q      <= bus.malu_result_mul[31:0];
            end else begin
              state_q      <= RESP;
              malu_uop_q   <= '0;
              rsp_valid_q  <= 1'b1;
              rsp_err_q    <= 1'b0;
              rsp_result_q <= malu_uop_q[6] ?
                              {bus.malu_result_div_r, bus.malu_result_div_q} :
                              bus.malu_result_mul;
            end
          end else if (wd_hit) begin
            malu_valid_q <= 1'b0;
            malu_uop_q   <= '0;
            wd_q         <= '0;
            state_q      <= RESP;
            rsp_valid_q  <= 1'b1;
            rsp_err_q    <= 1'b1;
            rsp_result_q <= '0;
          end else begin
            wd_q <= wd_q + 8'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_err        = rsp_err_q;
  assign bus.rsp_result     = rsp_result_q;
  assign bus.malu_valid     = malu_valid_q;
  assign bus.malu_flush     = malu_done || wd_hit;
  assign bus.malu_uop       = malu_uop_q;
  assign bus.malu_lh_sign   = lh_sign_q;
  assign bus.malu_rh_sign   = rh_sign_q;
  assign bus.malu_carryless = carryless_q;
  assign bus.malu_pw        = pw_q;
  assign bus.malu_rs1       = rs1_q;
  assign bus.malu_rs2       = rs2_q;
  assign bus.malu_rs3       = rs3_q;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_xc_malu_seq.sv
// Bench for xc_malu_seq: a table of requests with hand-computed results,
// plus hand-written sequences for two-phase ops, watchdog, back-pressure
// and reset. A small MALU stand-in answers micro-ops after a set latency.
module tb_xc_malu_seq;
  localparam int MAXC = 8;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [1:0] dbg_state;

  xc_malu_seq_if bus();

  xc_malu_seq #(.MAX_CYCLES(MAXC)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // MALU stand-in: mode 0 arithmetic, 1 phase stub (0x11 / 0x22), 2 never ready
  int model_mode = 0;
  int model_lat  = 2;
  int model_cnt  = 0;
  logic [63:0] ma, mb, mp;

  initial begin
    bus.malu_ready        = 1'b0;
    bus.malu_result_mul   = '0;
    bus.malu_result_div_q = '0;
    bus.malu_result_div_r = '0;
    forever begin
      @(posedge clock);
      #2;
      if (bus.malu_valid && model_mode != 2) begin
        if (model_cnt >= model_lat - 1) begin
          bus.malu_ready = 1'b1;
          if (bus.malu_uop[6]) begin
            if (bus.malu_rs2 == 32'd0) begin
              bus.malu_result_div_q = 32'hFFFF_FFFF;
              bus.malu_result_div_r = bus.malu_rs1;
            end else if (bus.malu_lh_sign) begin
              bus.malu_result_div_q = $signed(bus.malu_rs1) / $signed(bus.malu_rs2);
              bus.malu_result_div_r = $signed(bus.malu_rs1) % $signed(bus.malu_rs2);
            end else begin
              bus.malu_result_div_q = bus.malu_rs1 / bus.malu_rs2;
              bus.malu_result_div_r = bus.malu_rs1 % bus.malu_rs2;
            end
          end else if (model_mode == 1) begin
            bus.malu_result_mul = (bus.malu_uop[3] || bus.malu_uop[1]) ? 64'h11 : 64'h22;
          end else if (bus.malu_carryless) begin
            mp = '0;
            for (int i = 0; i < 32; i++) begin
              if (bus.malu_rs2[i]) mp = mp ^ ({32'd0, bus.malu_rs1} << i);
            end
            bus.malu_result_mul = mp;
          end else begin
            ma = bus.malu_lh_sign ? {{32{bus.malu_rs1[31]}}, bus.malu_rs1} : {32'd0, bus.malu_rs1};
            mb = bus.malu_rh_sign ? {{32{bus.malu_rs2[31]}}, bus.malu_rs2} : {32'd0, bus.malu_rs2};
            bus.malu_result_mul = ma * mb;
          end
        end else begin
          bus.malu_ready = 1'b0;
          model_cnt++;
        end
      end else begin
        bus.malu_ready = 1'b0;
        model_cnt = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic        lh, rh, cl;
    logic [2:0]  pw;
    logic [31:0] rs1, rs2, rs3;
    logic [63:0] exp_result;
    logic        exp_err;
    bit          exp_issue;
    logic [6:0]  exp_uop;
    logic [4:0]  exp_pw;
    logic        exp_rh, exp_cl;
    int          exp_flush;
    int          exp_lat;   // 0: latency not checked
  } vec_t;

  task automatic drive_req(input logic [2:0] op, input logic lh, input logic rh,
                           input logic cl, input logic [2:0] pw,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] rs3);
    bus.req_op = op; bus.req_lh_sign = lh; bus.req_rh_sign = rh;
    bus.req_carryless = cl; bus.req_pw = pw;
    bus.req_rs1 = rs1; bus.req_rs2 = rs2; bus.req_rs3 = rs3;
    bus.req_valid = 1'b1;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic rsp_handshake();
    bus.rsp_ready = 1'b1;
    @(posedge clock);
    #1 bus.rsp_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int cyc, flushes;
    bit seen, rdy_hi;
    cyc = 0; flushes = 0; seen = 0; rdy_hi = 0;
    drive_req(v.op, v.lh, v.rh, v.cl, v.pw, v.rs1, v.rs2, v.rs3);
    while (cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (bus.req_ready) rdy_hi = 1;
      if (bus.malu_flush) flushes++;
      if (bus.malu_valid && !seen) begin
        seen = 1;
        chk({v.name, ".uop"}, 64'(bus.malu_uop), 64'(v.exp_uop));
        chk({v.name, ".pw"}, 64'(bus.malu_pw), 64'(v.exp_pw));
        chk({v.name, ".rh"}, 64'(bus.malu_rh_sign), 64'(v.exp_rh));
        chk({v.name, ".cl"}, 64'(bus.malu_carryless), 64'(v.exp_cl));
        chk({v.name, ".rs1"}, 64'(bus.malu_rs1), 64'(v.rs1));
      end
      if (bus.rsp_valid) break;
    end
    chk({v.name, ".rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
    chk({v.name, ".result"}, bus.rsp_result, v.exp_result);
    chk({v.name, ".err"}, 64'(bus.rsp_err), 64'(v.exp_err));
    chk({v.name, ".flushes"}, 64'(flushes), 64'(v.exp_flush));
    chk({v.name, ".issued"}, 64'(seen), 64'(v.exp_issue));
    chk({v.name, ".req_ready_low"}, 64'(rdy_hi), 64'd0);
    if (v.exp_lat != 0) chk({v.name, ".latency"}, 64'(cyc), 64'(v.exp_lat));
    rsp_handshake();
  endtask

  vec_t vt[9];
  vec_t vb;
  int   cyc, flushes, vc, flush_at, gap;
  bit   s1, s2;

  initial begin
    // name, op, lh, rh, cl, pw, rs1, rs2, rs3, result, err, issue, uop, pw1h, rh, cl, flushes, lat
    vt[0] = '{"div_u",     3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd100, 32'd7, 32'd0,
              64'h00000002_0000000E, 1'b0, 1, 7'b1000000, 5'b10000, 1'b0, 1'b0, 1, 0};
    vt[1] = '{"div_s",     3'd0, 1'b1, 1'b0, 1'b1, 3'd2, 32'hFFFFFF9C, 32'd7, 32'd0,
              64'hFFFFFFFE_FFFFFFF2, 1'b0, 1, 7'b1000000, 5'b10000, 1'b1, 1'b0, 1, 0};
    vt[2] = '{"div_by0",   3'd0, 1'b1, 1'b1, 1'b0, 3'd0, 32'hFFFFFF9C, 32'd0, 32'd0,
              64'hFFFFFF9C_FFFFFFFF, 1'b0, 1, 7'b1000000, 5'b10000, 1'b1, 1'b0, 1, 0};
    vt[3] = '{"mul_u",     3'd1, 1'b0, 1'b0, 1'b0, 3'd0, 32'hFFFFFFFF, 32'd2, 32'd0,
              64'h00000001_FFFFFFFE, 1'b0, 1, 7'b0100000, 5'b10000, 1'b0, 1'b0, 1, 0};
    vt[4] = '{"mul_clmul", 3'd1, 1'b0, 1'b0, 1'b1, 3'd0, 32'd3, 32'd3, 32'd0,
              64'h5, 1'b0, 1, 7'b0100000, 5'b10000, 1'b0, 1'b1, 1, 0};
    vt[5] = '{"mul_s",     3'd1, 1'b1, 1'b1, 1'b0, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,
              64'h1, 1'b0, 1, 7'b0100000, 5'b10000, 1'b1, 1'b0, 1, 0};
    vt[6] = '{"madd",      3'd2, 1'b0, 1'b0, 1'b1, 3'd2, 32'd5, 32'd6, 32'd9,
              64'h1E, 1'b0, 1, 7'b0010000, 5'b00100, 1'b0, 1'b0, 1, 0};
    vt[7] = '{"ill_op",    3'd6, 1'b0, 1'b0, 1'b0, 3'd0, 32'd1, 32'd2, 32'd3,
              64'h0, 1'b1, 0, 7'b0, 5'b0, 1'b0, 1'b0, 0, 1};
    vt[8] = '{"ill_pw",    3'd1, 1'b0, 1'b0, 1'b0, 3'd7, 32'd1, 32'd2, 32'd3,
              64'h0, 1'b1, 0, 7'b0, 5'b0, 1'b0, 1'b0, 0, 1};

    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_lh_sign = 1'b0;
    bus.req_rh_sign = 1'b0; bus.req_carryless = 1'b0; bus.req_pw = '0;
    bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_rs3 = '0;
    bus.rsp_ready = 1'b0;

    // reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst.req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst.rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst.rsp_result", bus.rsp_result, 64'd0);
    chk("rst.malu_valid", 64'(bus.malu_valid), 64'd0);
    chk("rst.malu_uop", 64'(bus.malu_uop), 64'd0);
    chk("rst.state", 64'(dbg_state), 64'd0);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    // table
    for (int i = 0; i < 9; i++) run_vec(vt[i]);

    // MACC: two phases with one idle cycle between them
    model_mode = 1;
    cyc = 0; flushes = 0; gap = 0; s1 = 0; s2 = 0;
    drive_req(3'd4, 1'b0, 1'b0, 1'b0, 3'd0, 32'd1, 32'd2, 32'd3);
    while (cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (bus.malu_flush) flushes++;
      if (bus.malu_valid && bus.malu_uop == 7'b0000010 && !s1) begin
        s1 = 1;
        chk("macc.rs3_p1", 64'(bus.malu_rs3), 64'd3);
      end
      if (!bus.malu_valid && s1 && !s2) gap++;
      if (bus.malu_valid && bus.malu_uop == 7'b0000001 && !s2) begin
        s2 = 1;
        chk("macc.rs3_p2", 64'(bus.malu_rs3), 64'h11);
        chk("macc.rs2_p2", 64'(bus.malu_rs2), 64'd2);
        chk("macc.gap", 64'(gap), 64'd1);
      end
      if (bus.rsp_valid) break;
    end
    chk("macc.p1_seen", 64'(s1), 64'd1);
    chk("macc.p2_seen", 64'(s2), 64'd1);
    chk("macc.result", bus.rsp_result, 64'h22);
    chk("macc.err", 64'(bus.rsp_err), 64'd0);
    chk("macc.flushes", 64'(flushes), 64'd2);
    rsp_handshake();
    model_mode = 0;

    // watchdog abort, then back-pressure on the response
    model_mode = 2;
    cyc = 0; flushes = 0; vc = 0; flush_at = 0;
    drive_req(3'd1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd3, 32'd5, 32'd0);
    while (cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (bus.malu_valid) vc++;
      if (bus.malu_flush) begin
        flushes++;
        flush_at = vc;
      end
      if (bus.rsp_valid) break;
    end
    chk("wd.rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("wd.flush_at", 64'(flush_at), 64'(MAXC));
    chk("wd.flushes", 64'(flushes), 64'd1);
    chk("wd.err", 64'(bus.rsp_err), 64'd1);
    chk("wd.result", bus.rsp_result, 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("hold.rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("hold.err", 64'(bus.rsp_err), 64'd1);
    end
    rsp_handshake();
    model_mode = 0;

    // rsp_ready while no response is pending has no effect
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("stray_rdy.rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("stray_rdy.req_ready", 64'(bus.req_ready), 64'd1);
    chk("stray_rdy.state", 64'(dbg_state), 64'd0);
    bus.rsp_ready = 1'b0;
    @(posedge clock);
    #1;

    // completion in the same cycle the watchdog would fire
    model_lat = MAXC;
    vb = '{"mul_at_limit", 3'd1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd3, 32'd5, 32'd0,
           64'hF, 1'b0, 1, 7'b0100000, 5'b10000, 1'b0, 1'b0, 1, 0};
    run_vec(vb);
    model_lat = 2;

    // reset while in ISSUE1
    model_mode = 2;
    drive_req(3'd1, 1'b1, 1'b1, 1'b0, 3'd0, 32'd7, 32'd9, 32'd0);
    repeat (3) @(negedge clock);
    chk("rst_mid.busy", 64'(bus.malu_valid), 64'd1);
    resetn = 1'b0;
    #1;
    chk("rst_mid.req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_mid.rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_mid.malu_valid", 64'(bus.malu_valid), 64'd0);
    chk("rst_mid.malu_flush", 64'(bus.malu_flush), 64'd0);
    chk("rst_mid.malu_uop", 64'(bus.malu_uop), 64'd0);
    chk("rst_mid.malu_rs1", 64'(bus.malu_rs1), 64'd0);
    chk("rst_mid.lh", 64'(bus.malu_lh_sign), 64'd0);
    chk("rst_mid.state", 64'(dbg_state), 64'd0);
    @(negedge clock);
    resetn = 1'b1;
    model_mode = 0;
    @(posedge clock);
    #1;
    run_vec(vt[3]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // overall time bound
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
